// File: rtl/ascensor_pkg.sv
// Shared state codes and sizing helpers for the elevator cabin controller.
package ascensor_pkg;

   localparam int unsigned PISO_W = 4;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      MOVE = 2'd2,
      DOOR = 2'd3
   } estado_t;

   // Wide enough to hold the larger of T_PISO-1 and T_PUERTA-1.
   function automatic int unsigned timer_w(input int unsigned t_piso, input int unsigned t_puerta);
      int unsigned m;
      m = (t_piso > t_puerta) ? t_piso : t_puerta;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ascensor_timer.sv
// Loadable down-counter with a zero flag, shared by the travel and door phases.
module ascensor_timer
   import ascensor_pkg::*;
#(
   parameter int unsigned W = 2
)(
   input  logic         clk,
   input  logic         reset_L,
   input  logic         load,
   input  logic [W-1:0] valor,
   output logic         zero
);

   logic [W-1:0] cuenta;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         cuenta <= '0;
      else if (load)
         cuenta <= valor;
      else if (cuenta != '0)
         cuenta <= cuenta - W'(1);
   end

   assign zero = (cuenta == '0);

endmodule

// File: rtl/ascensor_ctrl.sv
// Elevator cabin controller: homes the floor counter, steps it towards the
// requested floor one step per travel interval, then holds the door open.
module ascensor_ctrl
   import ascensor_pkg::*;
#(
   parameter int unsigned N_PISOS  = 16,
   parameter int unsigned T_PISO   = 4,
   parameter int unsigned T_PUERTA = 8
)(
   input  logic              clk,
   input  logic              reset_L,
   input  logic              req,
   input  logic [PISO_W-1:0] req_piso,
   input  logic [PISO_W-1:0] Q,
   output logic              acepta,
   output logic              rechazo,
   output logic              enb,
   output logic              modo,
   output logic              dir,
   output logic [PISO_W-1:0] data,
   output logic              puerta,
   output logic              ocupado,
   output logic [1:0]        estado
);

   localparam int unsigned   TW           = timer_w(T_PISO, T_PUERTA);
   localparam logic [TW-1:0] CARGA_PISO   = TW'(T_PISO - 1);
   localparam logic [TW-1:0] CARGA_PUERTA = TW'(T_PUERTA - 1);
   localparam logic [PISO_W:0] LIMITE     = N_PISOS[PISO_W:0];

   estado_t           st, st_d;
   logic [PISO_W-1:0] destino, destino_d;
   logic              dir_q, dir_d;
   logic              en_destino;
   logic              acepta_d, rechazo_d;
   logic              tmr_load, tmr_zero;
   logic [TW-1:0]     tmr_valor;
   logic              valida;

   assign valida = ({1'b0, req_piso} < LIMITE);

   ascensor_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .reset_L (reset_L),
      .load    (tmr_load),
      .valor   (tmr_valor),
      .zero    (tmr_zero)
   );

   // Arrival is registered so no output depends combinationally on Q.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         st         <= INIT;
         destino    <= '0;
         dir_q      <= 1'b0;
         en_destino <= 1'b0;
         acepta     <= 1'b0;
         rechazo    <= 1'b0;
      end else begin
         st         <= st_d;
         destino    <= destino_d;
         dir_q      <= dir_d;
         en_destino <= (destino_d == Q);
         acepta     <= acepta_d;
         rechazo    <= rechazo_d;
      end
   end

   always_comb begin
      st_d      = st;
      destino_d = destino;
      dir_d     = dir_q;
      tmr_load  = 1'b0;
      tmr_valor = '0;
      acepta_d  = 1'b0;
      rechazo_d = req;
      enb       = 1'b0;
      modo      = 1'b0;
      dir       = 1'b0;
      data      = '0;
      puerta    = 1'b0;
      ocupado   = 1'b1;
      case (st)
         INIT: begin
            enb  = 1'b1;
            modo = 1'b1;
            st_d = IDLE;
         end
         IDLE: begin
            ocupado = 1'b0;
            if (req && valida) begin
               acepta_d  = 1'b1;
               rechazo_d = 1'b0;
               destino_d = req_piso;
               tmr_load  = 1'b1;
               if (req_piso == Q) begin
                  st_d      = DOOR;
                  tmr_valor = CARGA_PUERTA;
               end else begin
                  st_d      = MOVE;
                  dir_d     = (req_piso > Q);
                  tmr_valor = CARGA_PISO;
               end
            end
         end
         MOVE: begin
            dir = dir_q;
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (en_destino) begin
                  st_d      = DOOR;
                  tmr_valor = CARGA_PUERTA;
               end else begin
                  enb       = 1'b1;
                  tmr_valor = CARGA_PISO;
               end
            end
         end
         DOOR: begin
            puerta = 1'b1;
            if (tmr_zero)
               st_d = IDLE;
         end
         default: st_d = INIT;
      endcase
   end

   assign estado = st;

endmodule

// File: tb/tb_ascensor_ctrl.sv
// Directed bench for ascensor_ctrl paired with a behavioural floor counter.
module tb_ascensor_ctrl;

   localparam int unsigned TP = 2;
   localparam int unsigned TD = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_L, req, req12;
   logic [3:0] req_piso, piso12, data, data12;
   logic [3:0] q = 4'd7;
   logic [3:0] q12;
   logic       acepta, rechazo, enb, modo, dir, puerta, ocupado;
   logic       acepta12, rechazo12, enb12, modo12, dir12, puerta12, ocupado12;
   logic [1:0] estado, estado12;

   int checks = 0;
   int errors = 0;

   assign q12 = 4'd0;

   ascensor_ctrl #(.N_PISOS(16), .T_PISO(TP), .T_PUERTA(TD)) dut (
      .clk(clk), .reset_L(reset_L), .req(req), .req_piso(req_piso), .Q(q),
      .acepta(acepta), .rechazo(rechazo), .enb(enb), .modo(modo), .dir(dir),
      .data(data), .puerta(puerta), .ocupado(ocupado), .estado(estado)
   );

   ascensor_ctrl #(.N_PISOS(12), .T_PISO(TP), .T_PUERTA(TD)) dut12 (
      .clk(clk), .reset_L(reset_L), .req(req12), .req_piso(piso12), .Q(q12),
      .acepta(acepta12), .rechazo(rechazo12), .enb(enb12), .modo(modo12), .dir(dir12),
      .data(data12), .puerta(puerta12), .ocupado(ocupado12), .estado(estado12)
   );

   // Floor counter: load when modo=1, otherwise count in direction dir.
   always @(posedge clk)
      if (enb) q <= modo ? data : (dir ? q + 4'd1 : q - 4'd1);

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic viaje(input logic [3:0] piso, input int d, input logic sube, input int intr);
      int n = 0;
      int malos = 0;
      int subida = -1;
      int ancho = 0;
      req = 1'b1;
      req_piso = piso;
      @(negedge clk);
      req = 1'b0;
      check("acepta", acepta, 1);
      for (int c = 0; c < 200; c++) begin
         if (intr >= 0 && c == intr + 1) begin
            check("rechazo_busy", rechazo, 1);
            check("estado_busy", estado, 2);
         end
         if (enb) begin
            n++;
            if (c != n * TP - 1 || dir != sube || modo) malos++;
         end
         if (puerta) begin
            subida = c;
            break;
         end
         if (c == intr) begin
            req = 1'b1;
            req_piso = 4'd9;
         end
         @(negedge clk);
         req = 1'b0;
      end
      check("pulsos_enb", n, d);
      check("pulsos_malos", malos, 0);
      check("subida_puerta", subida, (d == 0) ? 0 : (d + 1) * TP);
      while (puerta && ancho < 50) begin
         ancho++;
         @(negedge clk);
      end
      check("ancho_puerta", ancho, TD);
      check("estado_fin", estado, 1);
      check("ocupado_fin", ocupado, 0);
      check("piso_fin", q, piso);
   endtask

   initial begin
      reset_L = 1'b0;
      req = 1'b0;
      req_piso = '0;
      req12 = 1'b0;
      piso12 = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_estado", estado, 0);
      check("rst_enb", enb, 1);
      check("rst_modo", modo, 1);
      check("rst_data", data, 0);
      check("rst_acepta", acepta, 0);
      check("rst_rechazo", rechazo, 0);
      check("rst_ocupado", ocupado, 1);
      check("rst_puerta", puerta, 0);

      reset_L = 1'b1;
      #1;
      check("init_ciclo", estado, 0);
      @(negedge clk);
      check("home_estado", estado, 1);
      check("home_q", q, 0);
      check("home_enb", enb, 0);
      check("home_ocupado", ocupado, 0);

      foreach (piso12[i]) piso12[i] = 1'b1;
      piso12 = 4'd12;
      req12 = 1'b1;
      @(negedge clk);
      req12 = 1'b0;
      check("n12_rechazo12", rechazo12, 1);
      check("n12_acepta12", acepta12, 0);
      check("n12_estado12", estado12, 1);
      piso12 = 4'd15;
      req12 = 1'b1;
      @(negedge clk);
      req12 = 1'b0;
      check("n12_rechazo15", rechazo12, 1);
      check("n12_estado15", estado12, 1);
      @(negedge clk);
      check("n12_pulso_uno", rechazo12, 0);

      viaje(4'd5, 5, 1'b1, -1);
      viaje(4'd2, 3, 1'b0, -1);
      viaje(4'd2, 0, 1'b0, -1);
      viaje(4'd6, 4, 1'b1, 2);
      viaje(4'd0, 6, 1'b0, -1);

      req = 1'b1;
      req_piso = 4'd9;
      @(negedge clk);
      req = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (q == 4'd4) break;
         @(negedge clk);
      end
      check("espera_q4", q, 4);
      reset_L = 1'b0;
      #1;
      check("mid_estado", estado, 0);
      check("mid_enb", enb, 1);
      check("mid_modo", modo, 1);
      check("mid_data", data, 0);
      check("mid_dir", dir, 0);
      check("mid_puerta", puerta, 0);
      check("mid_ocupado", ocupado, 1);
      @(negedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      @(negedge clk);
      check("mid_fin_q", q, 0);
      check("mid_fin_estado", estado, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ascensor_ctrl.md
# ascensor_ctrl

Elevator cabin controller that drives the 4-bit floor counter as its initiator. It issues the counter's `enb`/`modo`/`data` controls and reads its `Q` output back as the current floor. It accepts floor requests, steps the counter up or down one floor per travel interval, then holds the door open for a fixed time. It sits between the request logic and the floor counter inside the elevator ASM.

## Interface
- `N_PISOS`, default 16: number of valid floors, 0..N_PISOS-1; must be ≤16.
- `T_PISO`, default 4: cycles per floor step; must be ≥2 so each counter update is visible before the next step.
- `T_PUERTA`, default 8: cycles the door stays open; must be ≥1.

- `clk` in 1: single clock, rising edge.
- `reset_L` in 1: asynchronous, active-low reset.
- `req` in 1: floor request strobe, sampled on the rising edge.
- `req_piso` in 4: requested floor, valid while `req`=1.
- `Q` in 4: current floor, from the counter's output.
- `acepta` out 1: one-cycle pulse when a request is accepted.
- `rechazo` out 1: one-cycle pulse when a request is dropped (busy or invalid floor).
- `enb` out 1: counter enable.
- `modo` out 1: counter mode; 1 = load `data`, 0 = count.
- `dir` out 1: count direction; 1 = up, 0 = down.
- `data` out 4: counter load value.
- `puerta` out 1: door open.
- `ocupado` out 1: high in every state except IDLE.
- `estado` out 2: current state code.

## Operation
- States and codes: INIT=0, IDLE=1, MOVE=2, DOOR=3. `estado` reflects the registered state.
- **Reset.** Asserting `reset_L` low forces INIT immediately.
  - Register values while reset is held: target 0, timer 0, `acepta`=`rechazo`=0.
  - INIT drives `enb`=1, `modo`=1, `data`=0 for its single cycle, then goes to IDLE. This homes the counter to floor 0.
  - In INIT, `puerta`=0, `dir`=0, `ocupado`=1.
- **IDLE.** All counter controls are 0, `puerta`=0, `ocupado`=0.
  - On `req`=1 with `req_piso` < N_PISOS: latch the target, and register `acepta`=1 for the next cycle. Next state is chosen by comparing the target with `Q`:
    - target == `Q` → DOOR.
    - target > `Q` → MOVE with `dir`=1.
    - target < `Q` → MOVE with `dir`=0.
  - On `req`=1 with `req_piso` ≥ N_PISOS: stay in IDLE and pulse `rechazo`.
- **MOVE.** The timer loads T_PISO-1 on entry and decrements each cycle.
  - When the timer reaches 0 and `Q` ≠ target: `enb`=1, `modo`=0, `dir` held, for exactly one cycle; the timer then reloads.
  - When the timer reaches 0 and `Q` == target: go to DOOR with no `enb` pulse.
  - `dir` is latched when MOVE is entered and is constant for the whole move.
- **DOOR.** `puerta`=1. The timer loads T_PUERTA-1 on entry; at timer 0, go to IDLE.
- **Requests while busy.** A `req` in INIT, MOVE or DOOR is dropped and pulses `rechazo`. Requests are not queued.
- **Arithmetic.** Floor comparisons are 4-bit unsigned. The counter is never stepped past the target, so it never wraps from 15 to 0 or from 0 to 15.

## Timing
- All outputs are Moore outputs, decoded from registered state, timer, target and `dir`. There is no combinational path from `req`, `req_piso` or `Q` to any output.
- `acepta` and `rechazo` are high in the cycle after `req` is sampled, for one cycle only. `acepta` coincides with the first cycle of MOVE or DOOR.
- For travel distance d:
  - `puerta` rises (d+1)·T_PISO cycles after `acepta`.
  - For d=0, `puerta` rises in the same cycle as `acepta`.
- `enb` pulses during a move are spaced exactly T_PISO cycles apart; there are exactly d of them.
- `puerta` stays high for exactly T_PUERTA cycles. The first cycle after it falls is IDLE, and a new request is accepted in that cycle.
- Reset mid-move: outputs go to their INIT values asynchronously. The counter is reloaded to 0 in the first clocked cycle after `reset_L` rises.

## Structure
- Shared package `ascensor_pkg`:
  - state codes,
  - floor width (4),
  - timer width, sized as clog2(max(T_PISO, T_PUERTA)).
- Sub-module `ascensor_timer`: loadable down-counter with a `zero` flag, shared by MOVE and DOOR.
- The bench pairs this block with the existing floor counter, connecting `enb`, `modo`, `data`, `dir` and `Q`.

## Test plan
Parameters for all scenarios: T_PISO=2, T_PUERTA=3, N_PISOS=16.
- **Reset/home:** `reset_L` low, then high → one INIT cycle with `enb`=1, `modo`=1, `data`=0; `Q`=0; `estado`=1.
- **Move up:** `req_piso`=5 from floor 0 → `acepta`; exactly 5 `enb` pulses with `dir`=1, 2 cycles apart; `puerta` rises 12 cycles after `acepta`, lasts 3 cycles, then IDLE with `Q`=5.
- **Move down:** `req_piso`=2 from floor 5 → 3 pulses with `dir`=0; `puerta` rises 8 cycles after `acepta`; `Q`=2.
- **Same floor:** `req_piso`=2 at floor 2 → `acepta` and `puerta` rise in the same cycle; no `enb` pulse.
- **Dropped requests:**
  - `req` during MOVE → `rechazo` pulse, target unchanged.
  - `req_piso`=15 with N_PISOS=12 → `rechazo` pulse, stays in IDLE.
- **Reset mid-move:** assert reset while traveling 0→9 at `Q`=4 → outputs go to INIT values immediately; after release `Q`=0 and `estado`=1.
